// File: rtl/fetch_pair_buffer.sv
// Dual-issue instruction buffer: 0-2 {pc,instr} in, two oldest entries presented as A/B, 0-2 taken per cycle.
// Latency 1 cycle enqueue->dequeue (no bypass); enq_ready drops when fewer than two slots are free.
module fetch_pair_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     enq_vld_a,
    input  logic [31:0]              enq_pc_a,
    input  logic [31:0]              enq_instr_a,
    input  logic                     enq_vld_b,
    input  logic [31:0]              enq_pc_b,
    input  logic [31:0]              enq_instr_b,
    output logic                     enq_ready,
    output logic                     deq_vld_a,
    output logic [31:0]              deq_pc_a,
    output logic [31:0]              deq_instr_a,
    output logic                     deq_vld_b,
    output logic [31:0]              deq_pc_b,
    output logic [31:0]              deq_instr_b,
    input  logic [1:0]               deq_take,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     take_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } slot_t;

    slot_t mem_q [DEPTH];

    ptr_t  rd_ptr_q, rd_ptr_d;
    ptr_t  wr_ptr_q, wr_ptr_d;
    cnt_t  count_q, count_d;
    logic  take_err_q, take_err_d;

    ptr_t  rd_ptr_p1;
    ptr_t  wr_ptr_p1;
    logic  enq_fire;
    logic [1:0] n_in_raw;
    logic [1:0] take_clamp;
    cnt_t  n_in;
    cnt_t  take_req;
    cnt_t  n_out;
    logic  wr0_en;
    logic  wr1_en;
    slot_t wr0_dat;
    slot_t wr1_dat;
    slot_t rd_slot_a;
    slot_t rd_slot_b;

    always_comb begin
        rd_ptr_p1  = rd_ptr_q + ptr_t'(1);
        wr_ptr_p1  = wr_ptr_q + ptr_t'(1);

        // Readiness comes from registered occupancy only; a same-cycle take never frees room.
        enq_ready  = (count_q <= cnt_t'(DEPTH - 2));
        enq_fire   = enq_ready && !flush;

        n_in_raw   = {1'b0, enq_vld_a} + {1'b0, enq_vld_b};
        n_in       = enq_fire ? cnt_t'(n_in_raw) : '0;

        take_clamp = (deq_take == 2'd3) ? 2'd2 : deq_take;
        take_req   = cnt_t'(take_clamp);
        n_out      = (take_req > count_q) ? count_q : take_req;

        // A lone B slot is compacted into the head write position.
        wr0_en     = enq_fire && (enq_vld_a || enq_vld_b);
        wr1_en     = enq_fire && enq_vld_a && enq_vld_b;
        wr0_dat    = enq_vld_a ? slot_t'{pc: enq_pc_a, instr: enq_instr_a}
                               : slot_t'{pc: enq_pc_b, instr: enq_instr_b};
        wr1_dat    = slot_t'{pc: enq_pc_b, instr: enq_instr_b};

        rd_ptr_d   = rd_ptr_q + ptr_t'(n_out);
        wr_ptr_d   = wr_ptr_q + ptr_t'(n_in);
        count_d    = count_q + n_in - n_out;
        take_err_d = (take_req > count_q);

        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            take_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            take_err_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            take_err_q <= take_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem_q[wr_ptr_q] <= wr0_dat;
        end
        if (wr1_en) begin
            mem_q[wr_ptr_p1] <= wr1_dat;
        end
    end

    always_comb begin
        rd_slot_a   = mem_q[rd_ptr_q];
        rd_slot_b   = mem_q[rd_ptr_p1];

        deq_vld_a   = (count_q >= cnt_t'(1));
        deq_vld_b   = (count_q >= cnt_t'(2));
        deq_pc_a    = deq_vld_a ? rd_slot_a.pc    : 32'h0;
        deq_instr_a = deq_vld_a ? rd_slot_a.instr : 32'h0;
        deq_pc_b    = deq_vld_b ? rd_slot_b.pc    : 32'h0;
        deq_instr_b = deq_vld_b ? rd_slot_b.instr : 32'h0;

        count       = count_q;
        take_err    = take_err_q;
    end

endmodule
